// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan multiplexer.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBlank = 2'd1,
        StShow  = 2'd2
    } scan_state_e;

    localparam logic [7:0] SEG_DARK = 8'h00;

    function automatic int unsigned cnt_width(input int unsigned show_cyc,
                                              input int unsigned blank_cyc);
        int unsigned m;
        m = (show_cyc > blank_cyc) ? show_cyc : blank_cyc;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Loadable down-counter with terminal-count flag; shared by the BLANK and SHOW phases.
// With SEG_SCAN_DIM_EN defined the live count is exported for on-time gating.
module seg_scan_timer
    import seg_scan_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
`ifdef SEG_SCAN_DIM_EN
    output logic [W-1:0] count_o,
`endif
    output logic         tc_o
);

    logic [W-1:0] count_q, count_d;

    // Holds at zero rather than wrapping, so a missed reload can never alias a phase.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == '0);
`ifdef SEG_SCAN_DIM_EN
    assign count_o = count_q;
`endif

endmodule

// File: rtl/seg_scan_mux.sv
// Multiplexed seven-segment driver: per-digit pattern store, blank/show scan FSM, frame tick.
// Optional brightness gating within SHOW is enabled by defining SEG_SCAN_DIM_EN.
module seg_scan_mux
    import seg_scan_pkg::*;
#(
    parameter int unsigned DIGITS    = 4,
    parameter int unsigned SHOW_CYC  = 1000,
    parameter int unsigned BLANK_CYC = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                seg_in,
    input  logic                      load,
    input  logic [$clog2(DIGITS)-1:0] load_idx,
    input  logic                      enable,
`ifdef SEG_SCAN_DIM_EN
    input  logic [3:0]                bright,
`endif
    output logic [7:0]                seg_out,
    output logic [DIGITS-1:0]         dig_sel,
    output logic                      frame_tick
);

    localparam int unsigned IW = $clog2(DIGITS);
    localparam int unsigned CW = cnt_width(SHOW_CYC, BLANK_CYC);
    localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0] SHOW_LOAD  = CW'(SHOW_CYC - 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(DIGITS - 1);

    logic [7:0]        slot_q [DIGITS];
    logic [7:0]        slot_d [DIGITS];
    scan_state_e       state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [7:0]        seg_q, seg_d;
    logic [DIGITS-1:0] dig_q, dig_d;
    logic              tick_q, tick_d;

    logic              tmr_load;
    logic [CW-1:0]     tmr_val;
    logic              tmr_tc;
    logic [7:0]        cur_pat;
    logic [DIGITS-1:0] one_hot;

`ifdef SEG_SCAN_DIM_EN
    logic [CW-1:0]     tmr_count;
    logic [CW-1:0]     on_len_q, on_len_d;
    logic [7:0]        pat_q, pat_d;
    logic [DIGITS-1:0] hot_q, hot_d;
    logic              show_lit;

    function automatic logic [CW-1:0] on_time(input logic [3:0] b);
        int unsigned p;
        p = ((32'(b) + 32'd1) * SHOW_CYC) >> 4;
        return CW'(p);
    endfunction

    // Elapsed SHOW cycles after the coming edge is SHOW_CYC - count.
    assign show_lit = (int'(SHOW_CYC) - int'(tmr_count)) < int'(on_len_q);
`endif

    seg_scan_timer #(
        .W(CW)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (tmr_load),
        .load_val_i(tmr_val),
`ifdef SEG_SCAN_DIM_EN
        .count_o   (tmr_count),
`endif
        .tc_o      (tmr_tc)
    );

    // Out-of-range load_idx matches no slot, so the write is dropped.
    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            slot_d[i] = slot_q[i];
            if (load && (load_idx == IW'(i))) begin
                slot_d[i] = seg_in;
            end
        end
    end

    always_comb begin
        cur_pat = SEG_DARK;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_pat = slot_q[i];
            end
        end
    end

    assign one_hot = DIGITS'(1) << idx_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        seg_d    = seg_q;
        dig_d    = dig_q;
        tick_d   = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = BLANK_LOAD;
`ifdef SEG_SCAN_DIM_EN
        on_len_d = on_len_q;
        pat_d    = pat_q;
        hot_d    = hot_q;
`endif
        if (!enable) begin
            state_d = StIdle;
            idx_d   = '0;
            seg_d   = SEG_DARK;
            dig_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d  = StBlank;
                    idx_d    = '0;
                    seg_d    = SEG_DARK;
                    dig_d    = '0;
                    tmr_load = 1'b1;
                    tmr_val  = BLANK_LOAD;
                end
                StBlank: begin
                    if (tmr_tc) begin
                        state_d  = StShow;
                        tmr_load = 1'b1;
                        tmr_val  = SHOW_LOAD;
`ifdef SEG_SCAN_DIM_EN
                        on_len_d = on_time(bright);
                        pat_d    = cur_pat;
                        hot_d    = one_hot;
                        seg_d    = (on_len_d != '0) ? cur_pat : SEG_DARK;
                        dig_d    = (on_len_d != '0) ? one_hot : '0;
`else
                        seg_d    = cur_pat;
                        dig_d    = one_hot;
`endif
                    end
                end
                StShow: begin
                    if (tmr_tc) begin
                        state_d  = StBlank;
                        seg_d    = SEG_DARK;
                        dig_d    = '0;
                        tick_d   = (idx_q == LAST_IDX);
                        idx_d    = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
                        tmr_load = 1'b1;
                        tmr_val  = BLANK_LOAD;
                    end
`ifdef SEG_SCAN_DIM_EN
                    else begin
                        seg_d = show_lit ? pat_q : SEG_DARK;
                        dig_d = show_lit ? hot_q : '0;
                    end
`endif
                end
                default: begin
                    state_d = StIdle;
                    seg_d   = SEG_DARK;
                    dig_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DIGITS; i++) begin
                slot_q[i] <= SEG_DARK;
            end
            state_q  <= StIdle;
            idx_q    <= '0;
            seg_q    <= SEG_DARK;
            dig_q    <= '0;
            tick_q   <= 1'b0;
`ifdef SEG_SCAN_DIM_EN
            on_len_q <= '0;
            pat_q    <= SEG_DARK;
            hot_q    <= '0;
`endif
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                slot_q[i] <= slot_d[i];
            end
            state_q  <= state_d;
            idx_q    <= idx_d;
            seg_q    <= seg_d;
            dig_q    <= dig_d;
            tick_q   <= tick_d;
`ifdef SEG_SCAN_DIM_EN
            on_len_q <= on_len_d;
            pat_q    <= pat_d;
            hot_q    <= hot_d;
`endif
        end
    end

    assign seg_out    = seg_q;
    assign dig_sel    = dig_q;
    assign frame_tick = tick_q;

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Downstream of the single-digit seven-segment decoder.
- Captures the decoder's 8-bit segment patterns (7 segments + dp) into a per-digit register file, one digit per load strobe.
- Time-multiplexes the captured patterns onto a shared segment bus with one-hot digit enables.
- Inserts a blanking gap between digits to prevent ghosting; emits a frame tick once per full scan.

Parameters:
- DIGITS, 4, number of multiplexed digits (2..8).
- SHOW_CYC, 1000, clock cycles each digit is driven (>=2).
- BLANK_CYC, 2, clock cycles all digits are off between digits (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- seg_in  in  8  segment pattern from decoder; bit=1 means lit.
- load  in  1  write strobe; captures seg_in into slot load_idx on the sampled edge.
- load_idx  in  IW=$clog2(DIGITS)  target slot for load.
- enable  in  1  scan enable; 0 forces display dark.
- seg_out  out  8  shared segment bus, registered.
- dig_sel  out  DIGITS  one-hot digit enable, active-high, registered.
- frame_tick  out  1  one-cycle pulse at the end of the last digit's SHOW period.

Behaviour:
- Reset (async assert, sync release):
  - seg_out=0, dig_sel=0, frame_tick=0.
  - All slots=8'h00, digit index=0, cycle counter=0, state=IDLE.
- Register file writes:
  - load=1 writes seg_in to slot[load_idx] at the clock edge, independent of state and enable.
  - load_idx>=DIGITS: write ignored.
  - Written data appears on seg_out no earlier than that digit's next SHOW entry; patterns do not change mid-SHOW.
- FSM states: IDLE, BLANK, SHOW.
  - IDLE: outputs dark. enable=1 -> BLANK with counter=0, index=0.
  - BLANK: seg_out=0, dig_sel=0 for BLANK_CYC cycles. Then -> SHOW, latching slot[index] into seg_out and setting dig_sel=1<<index.
  - SHOW: outputs held for SHOW_CYC cycles. Then -> BLANK with index+1, wrapping DIGITS-1 -> 0.
  - Leaving SHOW from index DIGITS-1 pulses frame_tick for exactly one cycle, coincident with entry to BLANK.
- One full frame = DIGITS*(SHOW_CYC+BLANK_CYC) cycles.
- enable deassert in any state -> IDLE on the next edge; outputs dark on that edge, index reset to 0, no frame_tick.
- load on the same cycle as the SHOW latch into the same slot: the old value is shown and the new value is stored; the new value is shown next frame.
- dig_sel is never multi-hot, including across transitions. seg_out is nonzero only while dig_sel is nonzero.
- Counter width: $clog2(max(SHOW_CYC,BLANK_CYC)+1); counter and index wrap cleanly, with no overflow states.

Optional Feature:
- Macro: SEG_SCAN_DIM_EN.
- Defined:
  - Extra input port bright[3:0].
  - Within SHOW, dig_sel is active only while the SHOW counter < ((bright+1)*SHOW_CYC)>>4; segments are zeroed whenever dig_sel is zeroed.
  - bright=15 gives full on-time. bright is sampled at SHOW entry.
- Undefined: no port; full on-time as above.

Decomposition:
- Package seg_scan_pkg holds:
  - state enum (IDLE, BLANK, SHOW)
  - SEG_DARK=8'h00
  - helper function for counter width
- Sub-module seg_scan_timer: loadable down-counter with terminal-count flag. Instantiated once, shared between BLANK and SHOW.
- Register file and FSM stay in the top level.

Test Plan (DIGITS=4, SHOW_CYC=4, BLANK_CYC=2):
- Reset mid-scan: assert rst asynchronously while in SHOW -> seg_out=0, dig_sel=0 immediately; after release with enable=1, the first dig_sel=4'b0001 appears at cycle 2.
- Load 8'h7D, 8'h06, 8'h5B, 8'h4F into slots 0..3, then enable=1 -> seg_out sequence 7D,06,5B,4F with dig_sel 0001,0010,0100,1000, each held 4 cycles, with 2 dark cycles between; frame_tick pulses every 24 cycles.
- Load slot 2 with 8'hFF during digit 2 SHOW -> the current frame still shows the old value; the next frame shows FF.
- load_idx=5 with seg_in=8'hFF -> no slot changes; scan output unchanged.
- Drop enable during digit 1 SHOW -> dark on the next edge, no frame_tick; re-enable -> restarts at digit 0 after 2 blank cycles.
- With SEG_SCAN_DIM_EN defined and bright=7 (SHOW_CYC=16) -> each digit lit 8 of 16 SHOW cycles; bright=15 -> 16 of 16.
